// File: rtl/bsg_link_sif_wormhole_mux_if.sv
// ---------------------------------------------------------------------------
// bsg_link_sif_wormhole_mux_if
//   Bundles the ready_and links around bsg_link_sif_wormhole_mux.
//   Each link word is packed as {v, data[width_p-1:0], ready_and_rev}
//   (v in the MSB, ready_and_rev in the LSB).
//
//   links_i      : client side, fwd flits + client ready for return traffic
//   links_o      : client side, return flits + ready toward the clients
//   multi_link_i : link side, inbound flits + downstream ready
//   multi_link_o : link side, outbound flits + ready toward the link
//
//   slave  modport : used by the mux
//   master modport : used by whatever drives the mux
// ---------------------------------------------------------------------------
interface bsg_link_sif_wormhole_mux_if #(
  parameter int num_in_p = 2,
  parameter int width_p  = 32
);
  localparam int sif_width_lp = width_p + 2;

  logic [num_in_p-1:0][sif_width_lp-1:0] links_i;
  logic [num_in_p-1:0][sif_width_lp-1:0] links_o;
  logic [sif_width_lp-1:0]               multi_link_i;
  logic [sif_width_lp-1:0]               multi_link_o;

  modport slave  (input  links_i, multi_link_i, output links_o, multi_link_o);
  modport master (output links_i, multi_link_i, input  links_o, multi_link_o);
endinterface

// File: rtl/bsg_link_sif_wormhole_mux.sv
// ---------------------------------------------------------------------------
// bsg_link_sif_wormhole_mux
//   Merges num_in_p client ready_and links onto one shared link with
//   wormhole locking and round-robin fairness, and splits return traffic
//   back to the clients using the destination id in each header flit.
//
//   Header flit layout: [len_width_p-1:0]             body flit count
//                       [len_width_p +: lg_num_in_lp] destination client id
//
//   Ports:
//     clk_i, reset_i : clock, asynchronous active-high reset
//     link_if        : bsg_link_sif_wormhole_mux_if.slave (links_i/links_o,
//                      multi_link_i/multi_link_o)
//   Optional (macro BSG_LINK_SIF_WORMHOLE_MUX_PERF_EN):
//     perf_clear_i   : synchronous clear of the per-client flit counters
//     perf_flits_o   : per-client saturating count of accepted outbound flits
// ---------------------------------------------------------------------------

// Two-entry FIFO; ready is derived from occupancy only (never from yumi_i).
module bsg_link_sif_wormhole_mux_two_fifo #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  logic [1:0]         count_q, count_d;
  logic               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [width_p-1:0] mem_q [2];
  logic               enq, deq;

  assign ready_o = ~reset_i & (count_q != 2'd2);
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    count_d = count_q + {1'b0, enq} - {1'b0, deq};
    wptr_d  = wptr_q ^ enq;
    rptr_d  = rptr_q ^ deq;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end
endmodule

module bsg_link_sif_wormhole_mux #(
  parameter int num_in_p    = 2,
  parameter int width_p     = 32,
  parameter int len_width_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_link_sif_wormhole_mux_if.slave link_if
`ifdef BSG_LINK_SIF_WORMHOLE_MUX_PERF_EN
  , input  logic                       perf_clear_i
  , output logic [num_in_p-1:0][31:0]  perf_flits_o
`endif
);
  localparam int lg_num_in_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int idx_w_lp     = lg_num_in_lp + 1;
  localparam int sif_width_lp = width_p + 2;

  typedef enum logic {O_IDLE, O_LOCKED} out_state_e;
  typedef enum logic [1:0] {I_IDLE, I_ROUTE, I_DROP} in_state_e;

  // Unpacked client link fields
  logic [num_in_p-1:0] cli_v, cli_rdy, cli_ready_o, ret_v;
  logic [width_p-1:0]  cli_data [num_in_p];

  always_comb begin
    for (int i = 0; i < num_in_p; i++) begin
      cli_v[i]    = link_if.links_i[i][sif_width_lp-1];
      cli_data[i] = link_if.links_i[i][width_p:1];
      cli_rdy[i]  = link_if.links_i[i][0];
    end
  end

  // ------------------------------------------------------------------ outbound
  out_state_e               out_state_q, out_state_d;
  logic [lg_num_in_lp-1:0]  owner_q, owner_d, rr_q, rr_d;
  logic [len_width_p-1:0]   ocnt_q, ocnt_d;

  logic [idx_w_lp-1:0]      idx;
  logic                     any_v, locked, sel_v, accept;
  logic [lg_num_in_lp-1:0]  grant, sel;
  logic [width_p-1:0]       sel_data;
  logic [len_width_p-1:0]   out_len;
  logic                     out_ready, out_v;
  logic [width_p-1:0]       out_data;

  // First requester at or after rr_q, wrapping modulo num_in_p.
  always_comb begin
    any_v = 1'b0;
    grant = rr_q;
    idx   = '0;
    for (int k = 0; k < num_in_p; k++) begin
      idx = {1'b0, rr_q} + idx_w_lp'(k);
      if (idx >= idx_w_lp'(num_in_p)) idx = idx - idx_w_lp'(num_in_p);
      if (!any_v && cli_v[idx[lg_num_in_lp-1:0]]) begin
        any_v = 1'b1;
        grant = idx[lg_num_in_lp-1:0];
      end
    end
  end

  assign locked   = (out_state_q == O_LOCKED);
  assign sel      = locked ? owner_q : grant;
  assign sel_v    = locked ? cli_v[owner_q] : any_v;
  assign sel_data = cli_data[sel];
  assign out_len  = sel_data[len_width_p-1:0];
  assign accept   = sel_v & out_ready;

  // Only the granted/locked client sees ready; everyone else is held upstream.
  always_comb begin
    for (int i = 0; i < num_in_p; i++) begin
      cli_ready_o[i] = out_ready & (locked | any_v) & (sel == lg_num_in_lp'(i));
    end
  end

  always_comb begin
    out_state_d = out_state_q;
    owner_d     = owner_q;
    ocnt_d      = ocnt_q;
    rr_d        = rr_q;
    if (accept) begin
      if (!locked) begin
        rr_d = (grant == lg_num_in_lp'(num_in_p - 1)) ? '0 : grant + lg_num_in_lp'(1);
        if (out_len != '0) begin
          out_state_d = O_LOCKED;
          owner_d     = grant;
          ocnt_d      = out_len;
        end
      end else begin
        ocnt_d = ocnt_q - len_width_p'(1);
        if (ocnt_q == len_width_p'(1)) out_state_d = O_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_state_q <= O_IDLE;
      owner_q     <= '0;
      ocnt_q      <= '0;
      rr_q        <= '0;
    end else begin
      out_state_q <= out_state_d;
      owner_q     <= owner_d;
      ocnt_q      <= ocnt_d;
      rr_q        <= rr_d;
    end
  end

  bsg_link_sif_wormhole_mux_two_fifo #(.width_p(width_p)) out_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (sel_v),
    .data_i  (sel_data),
    .ready_o (out_ready),
    .v_o     (out_v),
    .data_o  (out_data),
    .yumi_i  (out_v & link_if.multi_link_i[0])
  );

  // ------------------------------------------------------------------- inbound
  in_state_e                in_state_q, in_state_d;
  logic [lg_num_in_lp-1:0]  dest_q, dest_d;
  logic [len_width_p-1:0]   icnt_q, icnt_d;

  logic                     in_ready, in_v, in_deq, dest_ok;
  logic [width_p-1:0]       in_data;
  logic [lg_num_in_lp-1:0]  hdr_dest;
  logic [len_width_p-1:0]   hdr_len;

  assign hdr_dest = in_data[len_width_p +: lg_num_in_lp];
  assign hdr_len  = in_data[len_width_p-1:0];
  // Out-of-range ids only exist when num_in_p is not a power of two.
  assign dest_ok  = (32'(hdr_dest) < num_in_p);

  always_comb begin
    ret_v      = '0;
    in_deq     = 1'b0;
    in_state_d = in_state_q;
    dest_d     = dest_q;
    icnt_d     = icnt_q;
    case (in_state_q)
      I_IDLE: begin
        if (dest_ok) begin
          ret_v[hdr_dest] = in_v;
          in_deq          = in_v & cli_rdy[hdr_dest];
        end else begin
          in_deq = in_v;
        end
        if (in_deq && hdr_len != '0) begin
          in_state_d = dest_ok ? I_ROUTE : I_DROP;
          dest_d     = hdr_dest;
          icnt_d     = hdr_len;
        end
      end
      I_ROUTE: begin
        ret_v[dest_q] = in_v;
        in_deq        = in_v & cli_rdy[dest_q];
      end
      I_DROP:  in_deq = in_v;
      default: in_state_d = I_IDLE;
    endcase
    if (in_state_q != I_IDLE && in_deq) begin
      icnt_d = icnt_q - len_width_p'(1);
      if (icnt_q == len_width_p'(1)) in_state_d = I_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      in_state_q <= I_IDLE;
      dest_q     <= '0;
      icnt_q     <= '0;
    end else begin
      in_state_q <= in_state_d;
      dest_q     <= dest_d;
      icnt_q     <= icnt_d;
    end
  end

  bsg_link_sif_wormhole_mux_two_fifo #(.width_p(width_p)) in_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (link_if.multi_link_i[sif_width_lp-1]),
    .data_i  (link_if.multi_link_i[width_p:1]),
    .ready_o (in_ready),
    .v_o     (in_v),
    .data_o  (in_data),
    .yumi_i  (in_deq)
  );

  // Return data is broadcast; only the routed client sees v.
  always_comb begin
    for (int i = 0; i < num_in_p; i++) begin
      link_if.links_o[i] = {ret_v[i], in_data, cli_ready_o[i]};
    end
  end
  assign link_if.multi_link_o = {out_v, out_data, in_ready};

`ifdef BSG_LINK_SIF_WORMHOLE_MUX_PERF_EN
  logic [num_in_p-1:0][31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < num_in_p; i++) begin
      if (perf_clear_i) perf_d[i] = '0;
      else if (accept && sel == lg_num_in_lp'(i) && perf_q[i] != 32'hFFFF_FFFF)
        perf_d[i] = perf_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_flits_o = perf_q;
`endif
endmodule

// File: tb/tb_bsg_link_sif_wormhole_mux.sv
module tb_bsg_link_sif_wormhole_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DUT A: four clients
  bsg_link_sif_wormhole_mux_if #(.num_in_p(4), .width_p(32)) a_if ();
  logic [3:0]  a_v = '0, a_rr = '1;
  logic [31:0] a_d [4];
  logic        a_mv = 1'b0, a_mrdy = 1'b1;
  logic [31:0] a_md = '0;
  wire  [3:0]  a_lo_v, a_lo_rdy;
  wire  [31:0] a_lo_d  = a_if.links_o[0][32:1];
  wire         a_mo_v  = a_if.multi_link_o[33];
  wire  [31:0] a_mo_d  = a_if.multi_link_o[32:1];
  wire         a_mo_rdy = a_if.multi_link_o[0];

  for (genvar i = 0; i < 4; i++) begin : g_a
    assign a_if.links_i[i] = {a_v[i], a_d[i], a_rr[i]};
    assign a_lo_v[i]   = a_if.links_o[i][33];
    assign a_lo_rdy[i] = a_if.links_o[i][0];
  end
  assign a_if.multi_link_i = {a_mv, a_md, a_mrdy};

  // DUT B: three clients (non power of two ids)
  bsg_link_sif_wormhole_mux_if #(.num_in_p(3), .width_p(32)) b_if ();
  logic [2:0]  b_v = '0, b_rr = '1;
  logic        b_mv = 1'b0, b_mrdy = 1'b1;
  logic [31:0] b_md = '0;
  wire  [2:0]  b_lo_v, b_lo_rdy;
  wire  [31:0] b_lo_d   = b_if.links_o[0][32:1];
  wire         b_mo_v   = b_if.multi_link_o[33];
  wire         b_mo_rdy = b_if.multi_link_o[0];

  for (genvar i = 0; i < 3; i++) begin : g_b
    assign b_if.links_i[i] = {b_v[i], 32'h0, b_rr[i]};
    assign b_lo_v[i]   = b_if.links_o[i][33];
    assign b_lo_rdy[i] = b_if.links_o[i][0];
  end
  assign b_if.multi_link_i = {b_mv, b_md, b_mrdy};

`ifdef BSG_LINK_SIF_WORMHOLE_MUX_PERF_EN
  logic             perf_clear = 1'b0;
  logic [3:0][31:0] a_perf;
  logic [2:0][31:0] b_perf;
`endif

  bsg_link_sif_wormhole_mux #(.num_in_p(4), .width_p(32), .len_width_p(4)) dut_a (
    .clk_i   (clk),
    .reset_i (rst),
    .link_if (a_if)
`ifdef BSG_LINK_SIF_WORMHOLE_MUX_PERF_EN
    , .perf_clear_i (perf_clear)
    , .perf_flits_o (a_perf)
`endif
  );

  bsg_link_sif_wormhole_mux #(.num_in_p(3), .width_p(32), .len_width_p(4)) dut_b (
    .clk_i   (clk),
    .reset_i (rst),
    .link_if (b_if)
`ifdef BSG_LINK_SIF_WORMHOLE_MUX_PERF_EN
    , .perf_clear_i (perf_clear)
    , .perf_flits_o (b_perf)
`endif
  );

  logic [31:0] src [4][$];
  logic [31:0] msrc [$];
  logic [32:0] obs [$];
  logic [31:0] dlv [$];
  int          dlv_cli [$];
  int          dlv_cyc [$];
  int          others;

  // Drives client sources on DUT A, records {v,data} of multi_link_o per cycle.
  task automatic out_run(input int ncyc);
    logic [3:0] fire;
    fire = '0;
    obs.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) if (fire[i]) void'(src[i].pop_front());
      #1;
      for (int i = 0; i < 4; i++) begin
        a_v[i] = (src[i].size() != 0);
        a_d[i] = a_v[i] ? src[i][0] : 32'h0;
      end
      #1;
      fire = a_v & a_lo_rdy;
      obs.push_back({a_mo_v, a_mo_d});
    end
  endtask

  // Inbound on DUT A; client 1 ready follows 1,0,1,1 starting at cycle 1.
  task automatic in_run_a(input int ncyc);
    logic mfire;
    mfire = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      if (mfire) void'(msrc.pop_front());
      #1;
      a_mv = (msrc.size() != 0);
      a_md = a_mv ? msrc[0] : 32'h0;
      a_rr = 4'b1111;
      a_rr[1] = (c != 2);
      #1;
      mfire = a_mv & a_mo_rdy;
      for (int j = 0; j < 4; j++) begin
        if (a_lo_v[j] && j != 1) others++;
        if (a_lo_v[j] && a_rr[j]) begin
          dlv.push_back(a_lo_d); dlv_cli.push_back(j); dlv_cyc.push_back(c);
        end
      end
    end
    a_mv = 1'b0;
  endtask

  // Inbound on DUT B; all clients ready; any v before cycle 4 is a violation.
  task automatic in_run_b(input int ncyc);
    logic mfire;
    mfire = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      if (mfire) void'(msrc.pop_front());
      #1;
      b_mv = (msrc.size() != 0);
      b_md = b_mv ? msrc[0] : 32'h0;
      #1;
      mfire = b_mv & b_mo_rdy;
      for (int j = 0; j < 3; j++) begin
        if (b_lo_v[j] && c < 4) others++;
        if (b_lo_v[j] && b_rr[j]) begin
          dlv.push_back(b_lo_d); dlv_cli.push_back(j); dlv_cyc.push_back(c);
        end
      end
    end
    b_mv = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    a_v = '0; b_v = '0; a_mv = 1'b0; b_mv = 1'b0;
    for (int i = 0; i < 4; i++) src[i].delete();
    msrc.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] exp2 [8];
  logic [31:0] exp4 [3];

  initial begin
    for (int i = 0; i < 4; i++) a_d[i] = 32'h0;
    exp2 = '{32'hC000_0003, 32'hC000_0101, 32'hC000_0102, 32'hC000_0103,
             32'hC200_0003, 32'hC200_0201, 32'hC200_0202, 32'hC200_0203};
    exp4 = '{32'h0000_0012, 32'hB100_0001, 32'hB100_0002};

    // Reset state
    @(posedge clk);
    #2;
    check("rst_a_cli_v",   64'(a_lo_v),   64'h0);
    check("rst_a_cli_rdy", 64'(a_lo_rdy), 64'h0);
    check("rst_a_mo_v",    64'(a_mo_v),   64'h0);
    check("rst_a_mo_rdy",  64'(a_mo_rdy), 64'h0);
    check("rst_b_cli_rdy", 64'(b_lo_rdy), 64'h0);
    check("rst_b_mo_rdy",  64'(b_mo_rdy), 64'h0);
    check("rst_rr",        64'(dut_a.rr_q), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rel_a_mo_rdy", 64'(a_mo_rdy), 64'h1);
    check("rel_b_mo_rdy", 64'(b_mo_rdy), 64'h1);
    check("idle_a_mo_v",  64'(a_mo_v),   64'h0);

    // Two locked packets, clients 0 and 2, len=3
    a_mrdy = 1'b1;
    for (int k = 0; k < 4; k++) src[0].push_back(exp2[k]);
    for (int k = 4; k < 8; k++) src[2].push_back(exp2[k]);
    out_run(11);
    check("wh_c0_v", 64'(obs[0][32]), 64'h0);
    for (int k = 0; k < 8; k++) check($sformatf("wh_flit%0d", k), 64'(obs[k+1]), {31'h0, 1'b1, exp2[k]});
    check("wh_c9_v", 64'(obs[9][32]), 64'h0);
    check("wh_rr",   64'(dut_a.rr_q), 64'h3);

    // Round robin with len=0 packets from all four clients
    do_reset();
    check("rr_after_rst", 64'(dut_a.rr_q), 64'h0);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) src[i].push_back(32'hD000_0000 | (i << 16) | (k << 8));
    out_run(11);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        check($sformatf("rr_k%0d_c%0d", k, i), 64'(obs[1 + 4*k + i]),
              {31'h0, 1'b1, 32'hD000_0000 | (i << 16) | (k << 8)});
    check("rr_end_v", 64'(obs[9][32]), 64'h0);

    // Inbound dest=1 len=2 with client-1 backpressure
    others = 0; dlv.delete(); dlv_cli.delete(); dlv_cyc.delete();
    for (int k = 0; k < 3; k++) msrc.push_back(exp4[k]);
    in_run_a(8);
    a_rr = 4'b1111;
    check("in_count", 64'(dlv.size()), 64'h3);
    for (int k = 0; k < 3; k++)
      check($sformatf("in_flit%0d", k), (k < dlv.size()) ? 64'(dlv[k]) : 64'hDEAD, 64'(exp4[k]));
    check("in_dst_cli", (dlv.size() == 3) ? 64'(dlv_cli[2]) : 64'hDEAD, 64'h1);
    check("in_last_cyc", (dlv.size() == 3) ? 64'(dlv_cyc[2]) : 64'hDEAD, 64'h4);
    check("in_others_v", 64'(others), 64'h0);

    // Drop on DUT B: dest=3 len=2, then dest=0 len=0
    others = 0; dlv.delete(); dlv_cli.delete(); dlv_cyc.delete();
    msrc.push_back(32'h0000_0032);
    msrc.push_back(32'hE000_0001);
    msrc.push_back(32'hE000_0002);
    msrc.push_back(32'hF000_0000);
    in_run_b(8);
    check("drop_no_v", 64'(others), 64'h0);
    check("drop_count", 64'(dlv.size()), 64'h1);
    check("drop_next_data", (dlv.size() != 0) ? 64'(dlv[0]) : 64'hDEAD, 64'hF000_0000);
    check("drop_next_cli",  (dlv.size() != 0) ? 64'(dlv_cli[0]) : 64'hDEAD, 64'h0);
    check("drop_next_cyc",  (dlv.size() != 0) ? 64'(dlv_cyc[0]) : 64'hDEAD, 64'h4);

    // Reset in the middle of a locked outbound packet
    a_mrdy = 1'b0;
    src[1].push_back(32'h1100_0003);
    src[1].push_back(32'h1100_0001);
    src[1].push_back(32'h1100_0002);
    src[1].push_back(32'h1100_0003);
    out_run(3);
    check("mid_fifo_v", 64'(obs[2][32]), 64'h1);
    check("mid_full_rdy", 64'(a_lo_rdy), 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    a_v = '0;
    for (int i = 0; i < 4; i++) src[i].delete();
    #1;
    check("mid_rst_v", 64'(a_mo_v), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    a_mrdy = 1'b1;
    src[3].push_back(32'h3300_0000);
    out_run(4);
    check("mid_new_flit", 64'(obs[1]), {31'h0, 1'b1, 32'h3300_0000});
    check("mid_no_stale", 64'(obs[2][32]), 64'h0);

`ifdef BSG_LINK_SIF_WORMHOLE_MUX_PERF_EN
    do_reset();
    src[1].push_back(32'h1000_0009);
    for (int k = 1; k < 10; k++) src[1].push_back(32'h1000_0000 | (k << 8));
    out_run(13);
    check("perf_c1_10", 64'(a_perf[1]), 64'd10);
    check("perf_c0_0",  64'(a_perf[0]), 64'd0);
    @(posedge clk);
    #1 a_v[1] = 1'b1; a_d[1] = 32'h0; perf_clear = 1'b1;
    #1 check("perf_acc_rdy", 64'(a_lo_rdy[1]), 64'h1);
    @(posedge clk);
    #1 a_v[1] = 1'b0; perf_clear = 1'b0;
    #1 check("perf_clear_wins", 64'(a_perf[1]), 64'd0);
    @(posedge clk);
    #1 a_v[1] = 1'b1;
    @(posedge clk);
    #1 a_v[1] = 1'b0;
    #1 check("perf_inc_after", 64'(a_perf[1]), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bsg_link_sif_wormhole_mux.md
Name: bsg_link_sif_wormhole_mux

Overview:
- Sits on the core side of an IO link block that has its channel tunnel bypassed (one ready_and link).
- Merges num_in_p client ready_and links onto that single link, with wormhole packet locking and round-robin fairness.
- Splits returning traffic back to the clients using a destination field carried in each header flit.
- Keeps multi-flit packets contiguous on the shared link so the remote mux can demux them.

Parameters:
- num_in_p, 2: number of client links; must be >= 2.
- width_p, 32: flit width; also the data width of every ready_and link.
- len_width_p, 4: header bits [len_width_p-1:0] hold the body flit count (0..2^len_width_p-1).
- lg_num_in_lp, `BSG_SAFE_CLOG2(num_in_p): header bits [len_width_p +: lg_num_in_lp] hold the destination client id.
- sif_width_lp, `bsg_ready_and_link_sif_width(width_p): width of one packed link struct (v, data, ready_and_rev).

Ports:
- clk_i  in  1  core clock; the only clock.
- reset_i  in  1  asynchronous, active-high reset.
- links_i  in  [num_in_p][sif_width_lp]  client-side links: client fwd flits plus client ready_and_rev for return traffic.
- links_o  out  [num_in_p][sif_width_lp]  client-side links: return flits plus ready_and_rev toward the clients.
- multi_link_i  in  sif_width_lp  link-side: inbound flits plus downstream ready_and_rev.
- multi_link_o  out  sif_width_lp  link-side: outbound flits plus ready_and_rev toward the link.

Behaviour:
- Reset (async assert, release synchronous to clk_i):
  - all v outputs = 0; all ready_and_rev outputs = 0 while reset is high.
  - both FSMs go to IDLE; rr pointer = 0; counters = 0.
- Outbound path:
  - Arbiter feeds a 2-entry output FIFO (bsg_two_fifo). Latency client -> multi_link_o.v is exactly 1 cycle; throughput is 1 flit/cycle.
  - A client is eligible in IDLE when its v=1. The grant is the first eligible client at or after rr_ptr (wrapping).
  - links_o[i].ready_and_rev = 1 only for the granted or locked client, and only when the FIFO is ready. All other clients see 0.
  - On header acceptance: rr_ptr <= (grant+1) mod num_in_p.
  - If the header's len=0: stay IDLE.
  - Else: go to LOCKED with owner=grant and cnt=len.
  - LOCKED: only owner is served. Each accepted flit decrements cnt. When cnt==1 and a flit is accepted, go to IDLE next cycle; a new grant may be issued that cycle with no bubble.
  - Non-owner v is ignored while LOCKED; their flits stay held upstream.
- Inbound path:
  - multi_link_i data enters a 2-entry input FIFO; multi_link_o.ready_and_rev = that FIFO's ready.
  - IDLE: the head flit is a header; dest = its id field.
  - dest < num_in_p: links_o[dest].v = FIFO v. Dequeue when links_i[dest].ready_and_rev & v. Lock the route for len body flits (same counting as outbound).
  - dest >= num_in_p (only possible when num_in_p is not a power of 2): enter DROP. Dequeue the header and len body flits unconditionally, one per cycle, with no client v asserted.
  - All other links_o[j].v = 0. links_o[*].data = FIFO head (broadcast).
- Simultaneous events:
  - Inbound and outbound are fully independent.
  - A header with len=0 accepted while others are waiting: the next grant happens the following cycle.
- Reset mid-packet:
  - Lock and counters are cleared; the partial packet is discarded from both FIFOs.
  - The upstream agent must also be reset; this is not checked.

Optional Feature:
- Macro: BSG_LINK_SIF_WORMHOLE_MUX_PERF_EN.
- Defined:
  - Adds output port perf_flits_o [num_in_p][32]: a per-client saturating count of outbound flits accepted from each client.
  - Adds input perf_clear_i [1]: synchronous clear of all counters; takes priority over increment in the same cycle.
  - Counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: neither port exists and no counter logic is present. Functional behaviour is otherwise identical.

Test Plan:
- Reset, then idle: all v=0, rr_ptr=0. After release, multi_link_o.ready_and_rev=1 within 1 cycle.
- num_in_p=4; clients 0 and 2 each present a header with len=3 at cycle 0:
  - client 0 sends 4 contiguous flits on cycles 1-4, then client 2 sends 4 flits on cycles 5-8.
  - no interleaving; rr_ptr=3 afterwards.
- All 4 clients send len=0 packets continuously with downstream ready=1: grant order is 0,1,2,3,0, ... at 1 flit/cycle.
- Inbound header dest=1, len=2; client 1 ready_and_rev toggles 1,0,1,1:
  - exactly 3 flits are delivered to client 1 in order.
  - links_o[0,2,3].v stays 0 throughout.
- num_in_p=3; inbound header dest=3, len=2:
  - 3 flits are dropped over 3 cycles with no client v.
  - the following header with dest=0 is delivered normally.
- With PERF_EN: 10 flits from client 1 give perf_flits_o[1]=10. Asserting perf_clear_i in the same cycle as a flit acceptance gives 0.
